ram_rd_sequencer: RTL and testbench

Read-side sequencer that sits directly downstream of the 8x16 dual-port RAM, in the read clock domain. Given a start pulse, base address and word count, it drives the RAM read port (`rd_en`, `rd_addr`), captures `data_out` after the RAM read latency, and presents the words as a valid/ready stream with a last-word flag. A 4-entry credit-controlled output buffer absorbs consumer backpressure without losing RAM data.

---
 rtl/ram_rd_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_ram_rd_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_rd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ram_rd_sequencer
// Purpose  : Burst read sequencer for a small synchronous RAM. It issues reads,
//            tags the returning data and streams it out through a 4-entry
//            credit-controlled buffer with valid/ready and a last-word flag.
// Revision : 1.0 - initial release
// ============================================================================
module ram_rd_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    localparam int BUF_DEPTH = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    // Read issue bookkeeping
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W:0]   rem;
    logic              rd_last;
    logic              accept;
    logic              issue;
    logic              done_nx;

    // Return-data tags, one stage per cycle of RAM latency
    logic [RD_LAT-1:0] vld_pipe;
    logic [RD_LAT-1:0] last_pipe;

    // Output buffer
    logic [DATA_W-1:0]    buf_data [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] buf_last;
    logic [1:0]           wr_ptr;
    logic [1:0]           rd_ptr;
    logic [2:0]           count;
    logic                 push;
    logic                 pop;

    // Credit accounting
    logic [3:0] pending;
    logic       credit_ok;

    assign push    = vld_pipe[RD_LAT-1];
    assign pop     = m_valid & m_ready;
    assign m_valid = (count != 3'd0);
    assign m_data  = buf_data[rd_ptr];
    assign m_last  = buf_last[rd_ptr] & m_valid;
    assign busy    = (state != S_IDLE);

    // Words already committed (read in flight or buffered) after this cycle's pop;
    // counting the pop keeps full throughput when the consumer is always ready.
    always_comb begin
        pending = {3'b000, rd_en} + {1'b0, count} - {3'b000, pop};
        for (int i = 0; i < RD_LAT; i++) begin
            pending = pending + {3'b000, vld_pipe[i]};
        end
        credit_ok = (pending < 4'd4);
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state and issue decisions; the first read issues on the accepting edge
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        issue    = 1'b0;
        done_nx  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && (len != '0)) begin
                    accept   = 1'b1;
                    issue    = 1'b1;
                    state_nx = (len == (ADDR_W+1)'(1)) ? S_DRAIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (rem == (ADDR_W+1)'(1)) begin
                        state_nx = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && m_last) begin
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Registered read port, address walk and remaining-word count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            rd_last   <= 1'b0;
            next_addr <= '0;
            rem       <= '0;
            done      <= 1'b0;
        end else begin
            rd_en <= issue;
            done  <= done_nx;
            if (issue) begin
                if (accept) begin
                    rd_addr   <= base_addr;
                    next_addr <= base_addr + ADDR_W'(1);
                    rem       <= len - (ADDR_W+1)'(1);
                    rd_last   <= (len == (ADDR_W+1)'(1));
                end else begin
                    rd_addr   <= next_addr;
                    next_addr <= next_addr + ADDR_W'(1);
                    rem       <= rem - (ADDR_W+1)'(1);
                    rd_last   <= (rem == (ADDR_W+1)'(1));
                end
            end else begin
                rd_last <= 1'b0;
            end
        end
    end

    // Tag pipeline aligned with the RAM read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            vld_pipe[0]  <= rd_en;
            last_pipe[0] <= rd_en & rd_last;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
        end
    end

    // Output FIFO; credits guarantee a push never finds it full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_data[i] <= '0;
            end
            buf_last <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= ram_dout;
                buf_last[wr_ptr] <= last_pipe[RD_LAT-1];
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_rd_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ram_rd_sequencer
// Purpose  : Directed bench for ram_rd_sequencer with a RAM model and a
//            scoreboard of expected stream words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_rd_sequencer;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int RD_LAT = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] ram_dout = '0;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    logic [DATA_W-1:0] mem [8];

    logic [DATA_W:0]   exp_q [$];
    logic [ADDR_W-1:0] addr_log [$];

    int compared   = 0;
    int mismatched = 0;
    int rd_en_cnt  = 0;
    int hs_cnt     = 0;
    int done_cnt   = 0;

    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data  = '0;
    logic              prev_last  = 1'b0;

    ram_rd_sequencer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .ram_dout  (ram_dout),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last)
    );

    always #5 clk = ~clk;

    // Single-cycle-latency RAM read port
    always @(posedge clk) begin
        if (rd_en) ram_dout <= mem[rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Negedge sampling: scoreboard pops, stall stability, read and done counting
    task automatic observe();
        logic [DATA_W:0] e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (rd_en) begin
                rd_en_cnt++;
                addr_log.push_back(rd_addr);
            end
            if (done) done_cnt++;
            if (prev_stall) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, prev_data);
                check("stall_last", m_last, prev_last);
            end
            if (m_valid && m_ready) begin
                hs_cnt++;
                check("word_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("stream_word", {m_last, m_data}, e);
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n, input bit push_exp);
        start     = 1'b1;
        base_addr = b;
        len       = n;
        if (push_exp) begin
            for (int i = 0; i < int'(n); i++) begin
                logic [ADDR_W-1:0] a;
                a = b + ADDR_W'(i);
                exp_q.push_back({(i == int'(n) - 1), mem[a]});
            end
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            tick();
            seen = done;
        end
        check(tag, seen, 1);
    endtask

    initial begin
        int rd0;
        int al0;
        int hs0;
        int dc0;

        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        m_ready   = 1'b1;
        mem[0] = 16'd11;  mem[1] = 16'd22;  mem[2] = 16'd33;  mem[3] = 16'd44;
        mem[4] = 16'd55;  mem[5] = 16'd200; mem[6] = 16'd140; mem[7] = 16'd60;

        // Reset state
        tick();
        tick();
        check("reset_outputs", {busy, done, rd_en, rd_addr, m_valid, m_data, m_last}, 0);
        rst = 1'b0;
        tick();

        // Basic burst with cycle-exact timing
        rd0 = rd_en_cnt;
        do_start(3'd5, 4'd3, 1'b1);
        check("basic_rd_en_e0", rd_en, 1);
        check("basic_rd_addr_e0", rd_addr, 5);
        check("basic_busy", busy, 1);
        check("basic_valid_e0", m_valid, 0);
        tick();
        check("basic_valid_e1", m_valid, 0);
        tick();
        check("basic_valid_e2", m_valid, 1);
        check("basic_data_e2", m_data, 200);
        check("basic_last_e2", m_last, 0);
        tick();
        check("basic_data_e3", m_data, 140);
        tick();
        check("basic_data_e4", m_data, 60);
        check("basic_last_e4", m_last, 1);
        tick();
        check("basic_done", done, 1);
        check("basic_busy_fall", busy, 0);
        tick();
        check("basic_done_pulse", done, 0);
        check("basic_rd_count", rd_en_cnt - rd0, 3);

        // Wrap-around, then back-to-back len=1 start in the done cycle
        al0 = addr_log.size();
        do_start(3'd6, 4'd4, 1'b1);
        wait_done("wrap_done", 30);
        check("wrap_addr_count", addr_log.size() - al0, 4);
        if (addr_log.size() - al0 == 4) begin
            check("wrap_addr0", addr_log[al0],   6);
            check("wrap_addr1", addr_log[al0+1], 7);
            check("wrap_addr2", addr_log[al0+2], 0);
            check("wrap_addr3", addr_log[al0+3], 1);
        end
        do_start(3'd1, 4'd1, 1'b1);
        check("b2b_busy", busy, 1);
        check("b2b_rd_en", rd_en, 1);
        check("b2b_rd_addr", rd_addr, 1);
        wait_done("b2b_done", 20);
        check("b2b_queue_empty", exp_q.size(), 0);

        // Backpressure: 4 credits, stall 6 cycles, then drain in order
        tick();
        m_ready = 1'b0;
        rd0 = rd_en_cnt;
        do_start(3'd0, 4'd8, 1'b1);
        for (int i = 0; i < 10 && !m_valid; i++) tick();
        check("bp_first_valid", m_valid, 1);
        repeat (6) tick();
        check("bp_outstanding", rd_en_cnt - rd0, 4);
        m_ready = 1'b1;
        wait_done("bp_done", 40);
        check("bp_rd_count", rd_en_cnt - rd0, 8);
        check("bp_queue_empty", exp_q.size(), 0);

        // Ignored starts
        tick();
        rd0 = rd_en_cnt;
        do_start(3'd3, 4'd0, 1'b1);
        tick();
        tick();
        check("len0_busy", busy, 0);
        check("len0_rd_count", rd_en_cnt - rd0, 0);
        do_start(3'd2, 4'd3, 1'b1);
        tick();
        do_start(3'd4, 4'd5, 1'b0);
        wait_done("busy_start_done", 30);
        check("busy_start_rd_count", rd_en_cnt - rd0, 3);
        check("busy_start_queue_empty", exp_q.size(), 0);

        // Asynchronous reset mid-burst after two delivered words
        tick();
        hs0 = hs_cnt;
        do_start(3'd3, 4'd5, 1'b1);
        for (int i = 0; i < 20 && (hs_cnt - hs0) < 2; i++) tick();
        check("mid_hs_count", hs_cnt - hs0, 2);
        dc0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        check("mid_reset_outputs", {busy, done, rd_en, rd_addr, m_valid, m_data, m_last}, 0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("mid_no_done", done_cnt - dc0, 0);
        check("mid_valid_cleared", m_valid, 0);
        do_start(3'd0, 4'd2, 1'b1);
        wait_done("post_reset_done", 20);
        check("post_reset_queue_empty", exp_q.size(), 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
